// File: rtl/sound_pkg.sv
// Shared definitions for the tone voice: sequencer states and the stock note
// pitch dividers used by melodies (values are sine clkgen maxvals).
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } seq_state_t;

    localparam logic [8:0] PITCH_A     = 9'd177;
    localparam logic [8:0] PITCH_DHIGH = 9'd133;
    localparam logic [8:0] PITCH_C     = 9'd149;
    localparam logic [8:0] PITCH_B     = 9'd158;
    localparam logic [8:0] PITCH_G     = 9'd199;
    localparam logic [8:0] PITCH_FIS   = 9'd211;
    localparam logic [8:0] PITCH_E     = 9'd237;
    localparam logic [8:0] PITCH_D     = 9'd266;

    localparam logic [8:0] PITCH_REST  = 9'd0;
    localparam logic [8:0] PITCH_IDLE  = 9'd511;

endpackage

// File: rtl/note_mem.sv
// Note table storage: one {pitch, duration} word per entry, synchronous write
// and registered read so it maps onto block RAM. Contents survive reset.
module note_mem #(
    parameter int ADDR_BITWIDTH = 5,
    parameter int DATA_BITWIDTH = 22
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_BITWIDTH-1:0] wr_addr,
    input  logic [DATA_BITWIDTH-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_BITWIDTH-1:0] rd_addr,
    output logic [DATA_BITWIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_BITWIDTH-1:0] rd_data_reg;

    // Read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/note_sequencer.sv
// Melody controller: steps through the note table at a fixed tick rate and
// drives the shared voice's pitch divider, restart pulse and mute.
module note_sequencer #(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int ADDR_BITWIDTH  = 5,
    parameter int TICK_MAXVAL    = 1250
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [ADDR_BITWIDTH-1:0]  last_addr,
    output logic [PITCH_BITWIDTH-1:0] pitch_o,
    output logic                      voice_reset_o,
    output logic                      mute_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_BITWIDTH-1:0]  cur_addr_o
);

    import sound_pkg::*;

    localparam int TICK_BITWIDTH  = (TICK_MAXVAL > 1) ? $clog2(TICK_MAXVAL) : 1;
    localparam int ENTRY_BITWIDTH = PITCH_BITWIDTH + DUR_BITWIDTH;
    localparam logic [TICK_BITWIDTH-1:0] TICK_LAST = TICK_BITWIDTH'(TICK_MAXVAL - 1);
    localparam logic [DUR_BITWIDTH-1:0]  DUR_ONE   = DUR_BITWIDTH'(1);

    seq_state_t                state_reg, state_next;
    logic [ADDR_BITWIDTH-1:0]  addr_reg, addr_next;
    logic [PITCH_BITWIDTH-1:0] pitch_reg, pitch_next;
    logic                      mute_reg, mute_next;
    logic [DUR_BITWIDTH-1:0]   dur_reg, dur_next;
    logic [DUR_BITWIDTH-1:0]   dur_cnt_reg, dur_cnt_next;
    logic [TICK_BITWIDTH-1:0]  tick_cnt_reg, tick_cnt_next;
    logic                      voice_reset_reg, voice_reset_next;
    logic                      done_reg, done_next;

    logic                      rd_en;
    logic [ENTRY_BITWIDTH-1:0] rd_data;
    logic [PITCH_BITWIDTH-1:0] rd_pitch;
    logic [DUR_BITWIDTH-1:0]   rd_dur;
    logic                      tick;
    logic                      note_end;

    // The read is launched on the edge that enters FETCH, so the entry is
    // already on rd_data during FETCH and can be latched as PLAY begins.
    assign rd_en = (state_next == FETCH);

    note_mem #(
        .ADDR_BITWIDTH (ADDR_BITWIDTH),
        .DATA_BITWIDTH (ENTRY_BITWIDTH)
    ) u_note_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_pitch, wr_dur}),
        .rd_en   (rd_en),
        .rd_addr (addr_next),
        .rd_data (rd_data)
    );

    assign rd_pitch = rd_data[ENTRY_BITWIDTH-1 -: PITCH_BITWIDTH];
    assign rd_dur   = rd_data[DUR_BITWIDTH-1:0];
    assign tick     = (tick_cnt_reg == TICK_LAST);
    assign note_end = tick && (dur_cnt_reg == dur_reg - DUR_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            pitch_reg       <= '1;
            mute_reg        <= 1'b1;
            dur_reg         <= DUR_ONE;
            dur_cnt_reg     <= '0;
            tick_cnt_reg    <= '0;
            voice_reset_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            pitch_reg       <= pitch_next;
            mute_reg        <= mute_next;
            dur_reg         <= dur_next;
            dur_cnt_reg     <= dur_cnt_next;
            tick_cnt_reg    <= tick_cnt_next;
            voice_reset_reg <= voice_reset_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        pitch_next       = pitch_reg;
        mute_next        = mute_reg;
        dur_next         = dur_reg;
        dur_cnt_next     = dur_cnt_reg;
        tick_cnt_next    = tick_cnt_reg;
        voice_reset_next = 1'b0;
        done_next        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end
            FETCH: begin
                state_next       = PLAY;
                pitch_next       = rd_pitch;
                mute_next        = (rd_pitch == PITCH_BITWIDTH'(PITCH_REST));
                dur_next         = (rd_dur == '0) ? DUR_ONE : rd_dur;
                tick_cnt_next    = '0;
                dur_cnt_next     = '0;
                voice_reset_next = 1'b1;
            end
            PLAY: begin
                tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_BITWIDTH'(1);
                if (tick) begin
                    dur_cnt_next = dur_cnt_reg + DUR_ONE;
                end
                if (note_end) begin
                    if (addr_reg != last_addr) begin
                        addr_next  = addr_reg + ADDR_BITWIDTH'(1);
                        state_next = FETCH;
                    end else if (loop_en) begin
                        addr_next  = '0;
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        mute_next  = 1'b1;
                        pitch_next = '1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // An abort overrides whatever the note logic decided this cycle.
        if (stop && (state_reg != IDLE)) begin
            state_next       = IDLE;
            addr_next        = addr_reg;
            mute_next        = 1'b1;
            pitch_next       = '1;
            voice_reset_next = 1'b1;
            done_next        = 1'b0;
        end
    end

    assign pitch_o       = pitch_reg;
    assign mute_o        = mute_reg;
    assign busy_o        = (state_reg != IDLE);
    assign voice_reset_o = voice_reset_reg;
    assign done_o        = done_reg;
    assign cur_addr_o    = addr_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected per-cycle outputs come from a timeline
// built note-by-note from the table contents (FETCH cycle + dur*tick PLAY cycles).
module tb_note_sequencer;
    import sound_pkg::*;

    localparam int PW = 9;
    localparam int DW = 13;
    localparam int AW = 5;
    localparam int T  = 4;
    localparam int MAXLEN = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_pitch = '0;
    logic [DW-1:0] wr_dur = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [PW-1:0] pitch_o;
    logic          voice_reset_o, mute_o, busy_o, done_o;
    logic [AW-1:0] cur_addr_o;

    always #5 clk = ~clk;

    note_sequencer #(
        .PITCH_BITWIDTH (PW),
        .DUR_BITWIDTH   (DW),
        .ADDR_BITWIDTH  (AW),
        .TICK_MAXVAL    (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_pitch      (wr_pitch),
        .wr_dur        (wr_dur),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .last_addr     (last_addr),
        .pitch_o       (pitch_o),
        .voice_reset_o (voice_reset_o),
        .mute_o        (mute_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cur_addr_o    (cur_addr_o)
    );

    // {pitch[17:9], mute[8], busy[7], vrst[6], done[5], addr[4:0]}
    typedef logic [17:0] obs_t;

    typedef struct {
        string name;
        bit    loop;
        int    last;
        int    len;
        int    stop_at;
        int    reset_at;
        int    restart_at;
        int    w_cycle;
        int    w_addr;
        int    w_pitch;
        int    w_dur;
        int    e_vrst;
        int    e_done;
        int    e_busy;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mp [32];
    int   md [32];
    obs_t exp_a [MAXLEN+1];

    function automatic obs_t pack(int p, bit m, bit b, bit v, bit d, int a);
        return {9'(p), m, b, v, d, 5'(a)};
    endfunction

    function automatic obs_t dut_obs();
        return {pitch_o, mute_o, busy_o, voice_reset_o, done_o, cur_addr_o};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pitch=%0d mute=%0b busy=%0b vrst=%0b done=%0b addr=%0d",
                         o[17:9], o[8], o[7], o[6], o[5], o[4:0]);
    endfunction

    function automatic vec_t mkvec(string name, bit loop, int last, int len, int stop_at,
                                   int reset_at, int restart_at, int w_cycle, int w_addr,
                                   int w_pitch, int w_dur, int e_vrst, int e_done, int e_busy);
        vec_t v;
        v.name = name;       v.loop = loop;         v.last = last;
        v.len = len;         v.stop_at = stop_at;   v.reset_at = reset_at;
        v.restart_at = restart_at;
        v.w_cycle = w_cycle; v.w_addr = w_addr;     v.w_pitch = w_pitch;
        v.w_dur = w_dur;     v.e_vrst = e_vrst;     v.e_done = e_done;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(int a, int p, int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_pitch = PW'(p); wr_dur = DW'(d);
        step();
        wr_en = 1'b0;
        mp[a] = p;
        md[a] = d;
    endtask

    // Cycle k = k-th cycle after the start pulse. Each note = one FETCH cycle
    // holding the previous pitch, then max(dur,1)*T cycles of the new pitch.
    task automatic build(input vec_t v);
        int   lp [32];
        int   ld [32];
        int   k = 1;
        int   i = 0;
        int   p, d;
        int   pp = 511;
        bit   pm = 1'b1;
        bit   fin = 1'b0;
        obs_t s_obs;
        for (int a = 0; a < 32; a++) begin
            lp[a] = mp[a];
            ld[a] = md[a];
        end
        while (k <= v.len && !fin) begin
            // The fetch of cycle k reads the table at the edge closing cycle k-1.
            if (v.w_cycle > 0 && v.w_cycle <= k - 2) begin
                lp[v.w_addr] = v.w_pitch;
                ld[v.w_addr] = v.w_dur;
            end
            p = lp[i];
            d = (ld[i] == 0) ? 1 : ld[i];
            if (k <= MAXLEN) exp_a[k] = pack(pp, pm, 1'b1, 1'b0, 1'b0, i);
            k++;
            for (int j = 0; j < d * T; j++) begin
                if (k <= MAXLEN) exp_a[k] = pack(p, p == 0, 1'b1, j == 0, 1'b0, i);
                k++;
            end
            pp = p;
            pm = (p == 0);
            if (i != v.last) begin
                i = (i + 1) % 32;
            end else if (v.loop) begin
                i = 0;
            end else begin
                if (k <= MAXLEN) exp_a[k] = pack(511, 1'b1, 1'b0, 1'b0, 1'b1, i);
                k++;
                while (k <= v.len) begin
                    exp_a[k] = pack(511, 1'b1, 1'b0, 1'b0, 1'b0, i);
                    k++;
                end
                fin = 1'b1;
            end
        end
        if (v.stop_at > 0) begin
            s_obs = exp_a[v.stop_at];
            if (s_obs[7]) begin
                for (int q = v.stop_at + 1; q <= v.len; q++)
                    exp_a[q] = pack(511, 1'b1, 1'b0, q == v.stop_at + 1, 1'b0, int'(s_obs[4:0]));
            end
        end
        if (v.reset_at > 0) begin
            for (int q = v.reset_at + 1; q <= v.len; q++)
                exp_a[q] = pack(511, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nv = 0;
        int nd = 0;
        int nb = 0;
        int bad0 = n_bad;
        build(v);
        loop_en = v.loop;
        last_addr = AW'(v.last);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= v.len; k++) begin
            check($sformatf("%s cyc%0d", v.name, k), dut_obs(), exp_a[k]);
            nv += int'(voice_reset_o);
            nd += int'(done_o);
            nb += int'(busy_o);
            if (k == v.stop_at)    stop = 1'b1;
            if (k == v.reset_at)   reset = 1'b1;
            if (k == v.restart_at) start = 1'b1;
            if (k == v.w_cycle) begin
                wr_en = 1'b1; wr_addr = AW'(v.w_addr);
                wr_pitch = PW'(v.w_pitch); wr_dur = DW'(v.w_dur);
            end
            step();
            stop = 1'b0; reset = 1'b0; start = 1'b0; wr_en = 1'b0;
        end
        if (v.w_cycle > 0) begin
            mp[v.w_addr] = v.w_pitch;
            md[v.w_addr] = v.w_dur;
        end
        if (v.e_vrst >= 0) check_int({v.name, " vrst_count"}, nv, v.e_vrst);
        if (v.e_done >= 0) check_int({v.name, " done_count"}, nd, v.e_done);
        if (v.e_busy >= 0) check_int({v.name, " busy_cycles"}, nb, v.e_busy);
        $display("run %s: %0d cycles vrst=%0d done=%0d busy=%0d errors=%0d",
                 v.name, v.len, nv, nd, nb, n_bad - bad0);
    endtask

    vec_t vecs [8];

    initial begin
        vec_t rv;
        for (int a = 0; a < 32; a++) begin
            mp[a] = 0;
            md[a] = 0;
        end

        // Reset state.
        step(); step();
        reset = 1'b0;
        check("reset_state", dut_obs(), pack(511, 1'b1, 1'b0, 1'b0, 1'b0, 0));

        // Start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("start_stop_idle cyc%0d", k), dut_obs(),
                  pack(511, 1'b1, 1'b0, 1'b0, 1'b0, 0));
            step();
        end
        $display("run start_stop_idle: busy stays low");

        write_entry(0, int'(PITCH_D), 2);
        write_entry(1, int'(PITCH_G), 1);
        write_entry(2, int'(PITCH_A), 3);
        write_entry(3, int'(PITCH_REST), 2);
        write_entry(4, int'(PITCH_B), 0);
        write_entry(5, int'(PITCH_E), 1);

        //                name            loop last len stop rst  rest wcyc wa wp   wd vrst done busy
        vecs[0] = mkvec("three_notes",    0,   2,   40, 0,   0,   0,   0,   0, 0,   0, 3,   1,   27);
        vecs[1] = mkvec("loop_stop",      1,   2,   50, 40,  0,   0,   0,   0, 0,   0, 6,   0,   40);
        vecs[2] = mkvec("rest_and_dur0",  0,   5,   60, 0,   0,   0,   0,   0, 0,   0, 6,   1,   46);
        vecs[3] = mkvec("start_in_play",  0,   2,   40, 0,   0,   12,  0,   0, 0,   0, 3,   1,   27);
        vecs[4] = mkvec("reset_mid_play", 0,   4,   30, 0,   20,  0,   0,   0, 0,   0, 3,   0,   20);
        vecs[5] = mkvec("replay_after_rst", 0, 2,   40, 0,   0,   0,   0,   0, 0,   0, 3,   1,   27);
        vecs[6] = mkvec("single_entry",   0,   0,   15, 0,   0,   0,   0,   0, 0,   0, 1,   1,   9);
        vecs[7] = mkvec("rewrite_playing", 1,  2,   60, 55,  0,   0,   13,  1, 149, 1, 7,   0,   55);

        for (int n = 0; n < 8; n++) run_vec(vecs[n]);

        // Randomized tables, lengths, loop mode and abort points.
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a < 8; a++)
                write_entry(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 511)),
                            int'($urandom_range(0, 3)));
            rv = mkvec($sformatf("rand%0d", r), 1'b0, int'($urandom_range(0, 7)),
                       110, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
            rv.loop = 1'($urandom_range(0, 1));
            if (rv.loop) begin
                rv.stop_at = int'($urandom_range(3, 140));
                rv.len = rv.stop_at + 3;
            end else if ($urandom_range(0, 1) == 1) begin
                rv.stop_at = int'($urandom_range(2, 60));
            end
            run_vec(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
